decoder_cs_gen: RTL and testbench

- Parametrised, registered successor to the team's combinational 2-to-4 decoder.
- Decodes an SEL_W-bit index into a one-hot chip-select vector of OUT_N lines.
- Holds the selected line for a programmable number of cycles, inserts an inter-select gap, then acknowledges.
- Sits between a bus controller issuing select requests and the peripheral chip-select pins.

---
 rtl/decoder_pkg.sv | 37 +++
 rtl/decoder_cs_gen_onehot.sv | 23 ++
 rtl/decoder_cs_gen.sv | 154 +++++++++++++++
 tb/tb_decoder_cs_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for the registered chip-select decoder.
//   cs_state_t    - controller states (IDLE, HOLD, GAP)
//   onehot_decode - index to one-hot, all-zero when the index is out of range
//   cnt_w         - counter width able to hold max(hold, gap) - 1
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } cs_state_t;

  // Returns a 32-bit one-hot word; zero when sel is outside 0..out_n-1, so
  // callers can derive the range-valid flag from the OR of the result.
  function automatic logic [31:0] onehot_decode(input logic [31:0] sel,
                                                input int unsigned out_n);
    logic [31:0] r;
    if (sel < out_n) begin
      r = 32'd1 << sel;
    end else begin
      r = 32'd0;
    end
    return r;
  endfunction

  // Counter holds values up to max(hold, gap) - 1; never narrower than 1 bit.
  function automatic int cnt_w(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    if (m <= 1) begin
      return 1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/decoder_cs_gen_onehot.sv
// decoder_onehot: combinational SEL_W -> OUT_N one-hot decode with range flag.
//   sel    - index to decode
//   onehot - one-hot vector, all zero when sel >= OUT_N
//   valid  - high when sel < OUT_N
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int OUT_N = 4
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] onehot,
  output logic             valid
);

  logic [31:0] full_s;

  assign full_s = onehot_decode(32'(sel), OUT_N);
  assign onehot = full_s[OUT_N-1:0];
  // A set bit can only appear below OUT_N, so any set bit means in range.
  assign valid  = |full_s;

endmodule

// File: rtl/decoder_cs_gen.sv
// decoder_cs_gen: registered one-hot chip-select generator.
// A request in IDLE latches sel, drives y[sel] for HOLD_CYCLES cycles, keeps
// all lines low for GAP_CYCLES cycles, then pulses ack. en low aborts.
//   clk, rst - clock, asynchronous active-high reset
//   en       - global enable; low aborts HOLD/GAP
//   req, sel - request strobe and index, sampled only in IDLE
//   y        - one-hot chip selects
//   busy     - high in HOLD and GAP
//   ack      - one-cycle pulse after normal completion
//   err      - one-cycle pulse on out-of-range request or abort
// Optional build macro DECODER_CS_TRISTATE_EN: y floats ('z) whenever it is
// not actively selecting (en low, IDLE or GAP); otherwise those cycles drive 0.
module decoder_cs_gen
  import decoder_pkg::*;
#(
  parameter int SEL_W       = 2,
  parameter int OUT_N       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] y,
  output logic             busy,
  output logic             ack,
  output logic             err
);

  localparam int            CW        = cnt_w(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : {CW{1'b0}};

  cs_state_t        state_r, state_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [SEL_W-1:0] sel_r, sel_n;
  logic [OUT_N-1:0] y_r, y_n;
  logic             busy_r, busy_n;
  logic             ack_r, ack_n;
  logic             err_r, err_n;

  logic [SEL_W-1:0] dec_sel_s;
  logic [OUT_N-1:0] dec_onehot_s;
  logic             dec_valid_s;

  // One decoder serves both jobs: in IDLE it range-checks the incoming index,
  // elsewhere it decodes the latched index that drives y.
  assign dec_sel_s = (state_r == IDLE) ? sel : sel_r;

  decoder_onehot #(
    .SEL_W (SEL_W),
    .OUT_N (OUT_N)
  ) u_dec (
    .sel    (dec_sel_s),
    .onehot (dec_onehot_s),
    .valid  (dec_valid_s)
  );

  // State, counter, latched select and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      y_r     <= {OUT_N{1'b0}};
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      sel_r   <= sel_n;
      y_r     <= y_n;
      busy_r  <= busy_n;
      ack_r   <= ack_n;
      err_r   <= err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    sel_n   = sel_r;
    y_n     = {OUT_N{1'b0}};
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && req) begin
          if (dec_valid_s) begin
            state_n = HOLD;
            sel_n   = sel;
            cnt_n   = HOLD_LOAD;
            y_n     = dec_onehot_s;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = {CW{1'b0}};
          err_n   = 1'b1;
        end else if (cnt_r == {CW{1'b0}}) begin
          // y drops on this edge; gap may be configured away entirely.
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = IDLE;
            ack_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt_r - {{(CW-1){1'b0}}, 1'b1};
          y_n   = dec_onehot_s;
        end
      end
      GAP: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = {CW{1'b0}};
          err_n   = 1'b1;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_n = IDLE;
          ack_n   = 1'b1;
        end else begin
          cnt_n = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CW{1'b0}};
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  assign busy = busy_r;
  assign ack  = ack_r;
  assign err  = err_r;

`ifdef DECODER_CS_TRISTATE_EN
  assign y = (en && state_r == HOLD) ? y_r : {OUT_N{1'bz}};
`else
  assign y = (en && state_r == HOLD) ? y_r : {OUT_N{1'b0}};
`endif

endmodule

// File: tb/tb_decoder_cs_gen.sv
// Self-checking bench: two instances (OUT_N=4 and OUT_N=3) share stimulus.
// A transaction-level model predicts each cycle's outputs from the time
// elapsed since acceptance; expectations are queued and a monitor compares.
module tb_decoder_cs_gen;

  localparam int H = 3;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst, en, req;
  logic [1:0] sel;
  logic [3:0] y4;
  logic [2:0] y3;
  logic       busy4, ack4, err4, busy3, ack3, err3;

  always #5 clk = ~clk;

  decoder_cs_gen #(.SEL_W(2), .OUT_N(4), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req), .sel(sel),
    .y(y4), .busy(busy4), .ack(ack4), .err(err4)
  );

  decoder_cs_gen #(.SEL_W(2), .OUT_N(3), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut3 (
    .clk(clk), .rst(rst), .en(en), .req(req), .sel(sel),
    .y(y3), .busy(busy3), .ack(ack3), .err(err3)
  );

  typedef struct packed {
    logic [3:0] y;
    logic       busy;
    logic       ack;
    logic       err;
  } exp_t;

`ifdef DECODER_CS_TRISTATE_EN
  localparam logic [3:0] IDLE_Y = 4'bzzzz;
`else
  localparam logic [3:0] IDLE_Y = 4'b0000;
`endif

  exp_t q4[$];
  exp_t q3[$];
  exp_t m4, m3;
  int   checks = 0;
  int   errors = 0;

  // Model state: edge counter, active transaction, its accept edge and index.
  int t = 0;
  bit act [2];
  int a_edge [2];
  int msel [2];
  int outn [2] = '{4, 3};

  function automatic exp_t model_edge(input int d, input logic e, input logic r,
                                      input logic [1:0] s);
    exp_t x;
    int   o;
    x.y = IDLE_Y; x.busy = 1'b0; x.ack = 1'b0; x.err = 1'b0;
    if (act[d]) begin
      if (!e) begin
        x.err  = 1'b1;
        act[d] = 1'b0;
      end else begin
        o = t - a_edge[d];
        if (o < H) begin
          x.y = 4'b0001 << msel[d];
          x.busy = 1'b1;
        end else if (o < H + G) begin
          x.busy = 1'b1;
        end else begin
          x.ack  = 1'b1;
          act[d] = 1'b0;
        end
      end
    end else if (e && r) begin
      if (int'(s) < outn[d]) begin
        act[d]    = 1'b1;
        a_edge[d] = t;
        msel[d]   = int'(s);
        x.y       = 4'b0001 << s;
        x.busy    = 1'b1;
      end else begin
        x.err = 1'b1;
      end
    end
    return x;
  endfunction

  task automatic step(input logic e, input logic r, input logic [1:0] s);
    @(negedge clk);
    en = e; req = r; sel = s;
    t++;
    q4.push_back(model_edge(0, e, r, s));
    q3.push_back(model_edge(1, e, r, s));
  endtask

  task automatic check_bits(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Monitor: compare each instance against its queued expectation.
  always @(posedge clk) begin
    #1;
    if (q4.size() != 0) begin
      m4 = q4.pop_front();
      checks++;
      if ({y4, busy4, ack4, err4} !== m4) begin
        errors++;
        $display("FAIL dut4_out t=%0d got y=%b busy=%b ack=%b err=%b want y=%b busy=%b ack=%b err=%b",
                 $time, y4, busy4, ack4, err4, m4.y, m4.busy, m4.ack, m4.err);
      end
    end
    if (q3.size() != 0) begin
      m3 = q3.pop_front();
      checks++;
      if ({y3, busy3, ack3, err3} !== {m3.y[2:0], m3.busy, m3.ack, m3.err}) begin
        errors++;
        $display("FAIL dut3_out t=%0d got y=%b busy=%b ack=%b err=%b want y=%b busy=%b ack=%b err=%b",
                 $time, y3, busy3, ack3, err3, m3.y[2:0], m3.busy, m3.ack, m3.err);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; req = 1'b0; sel = 2'd0;
    act = '{1'b0, 1'b0};
    #1;
    check_bits("reset4", {y4, busy4, ack4, err4}, {IDLE_Y, 3'b000});
    check_bits("reset3", {1'b0, y3, busy3, ack3, err3}, {1'b0, IDLE_Y[2:0], 3'b000});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single request, sel=2.
    step(1'b1, 1'b1, 2'd2);
    repeat (5) step(1'b1, 1'b0, 2'd0);
    // Back-to-back: sel=1, then sel=3 issued in the ack cycle.
    step(1'b1, 1'b1, 2'd1);
    repeat (4) step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 2'd3);
    repeat (5) step(1'b1, 1'b0, 2'd0);
    // Out of range on the OUT_N=3 instance.
    step(1'b1, 1'b1, 2'd3);
    repeat (5) step(1'b1, 1'b0, 2'd0);
    // req ignored while en is low.
    step(1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 2'd0);
    // Abort during the second HOLD cycle.
    step(1'b1, 1'b1, 2'd2);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    repeat (3) step(1'b1, 1'b0, 2'd0);

    // Asynchronous reset in the middle of HOLD.
    step(1'b1, 1'b1, 2'd2);
    step(1'b1, 1'b0, 2'd0);
    @(negedge clk);
    check_bits("midhold4", {y4, busy4, ack4, err4}, {4'b0100, 3'b100});
    #2 rst = 1'b1;
    #1;
    check_bits("async_rst4", {y4, busy4, ack4, err4}, {IDLE_Y, 3'b000});
    check_bits("async_rst3", {1'b0, y3, busy3, ack3, err3}, {1'b0, IDLE_Y[2:0], 3'b000});
    act = '{1'b0, 1'b0};
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(1'b1, 1'b0, 2'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) != 0, ($urandom % 3) == 0, 2'($urandom % 4));
    end
    step(1'b1, 1'b0, 2'd0);

    for (int i = 0; i < 10 && (q4.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    #2;
    if (q4.size() != 0 || q3.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending4=%0d pending3=%0d want 0", q4.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
